// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer: issues one valid/ready access per EX/MEM entry,
// stalls the pipeline while it is in flight, and formats load data.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;

    logic        w_access;
    logic        w_misal;
    logic        w_start;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_rbyte [4];
    logic [7:0]  w_sel_byte;
    logic [15:0] w_sel_half;
    logic [31:0] w_load_ext;

    assign w_access = mem_read | mem_write;
    // funct3[1:0]=11 has no RV32 meaning here and is handled as a word access
    assign w_size   = mem_funct3[1] ? SZ_WORD : (mem_funct3[0] ? SZ_HALF : SZ_BYTE);

    always_comb begin
        w_misal = 1'b0;
        case (w_size)
            SZ_HALF: w_misal = mem_addr[0];
            SZ_WORD: w_misal = |mem_addr[1:0];
            default: w_misal = 1'b0;
        endcase
    end

    assign w_start    = (r_state == ST_IDLE) && w_access && !w_misal;
    assign misaligned = rstn && (r_state == ST_IDLE) && w_access && w_misal;
    assign stall      = rstn && (w_start || (r_state == ST_ACCESS));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_wdata;
        if (mem_write) begin
            case (w_size)
                SZ_BYTE: begin
                    w_be    = 4'b0001 << mem_addr[1:0];
                    w_wdata = {4{mem_wdata[7:0]}};
                end
                SZ_HALF: begin
                    w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{mem_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = mem_wdata;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_rbyte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_sel_byte = w_rbyte[r_off];
    assign w_sel_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (r_size)
            SZ_BYTE: w_load_ext = {{24{~r_unsigned & w_sel_byte[7]}}, w_sel_byte};
            SZ_HALF: w_load_ext = {{16{~r_unsigned & w_sel_half[15]}}, w_sel_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_off      <= 2'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {mem_addr[31:2], 2'b00};
                        dmem_be    <= w_be;
                        dmem_wdata <= w_wdata;
                        r_size     <= w_size;
                        r_unsigned <= mem_funct3[2];
                        r_off      <= mem_addr[1:0];
                        r_cnt      <= 8'd1;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // ready wins over timeout when both land in the last allowed cycle
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data  <= w_load_ext;
                            load_valid <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else if (r_cnt == TIMEOUT_CNT) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed table, randomized accesses
// against an arithmetic reference model, and reset / back-to-back sequences.
module tb_mem_stage_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, misaligned, bus_err;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_ld;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rd;
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        k;
        bit        e_misal;
        int        e_stall;
        bit [31:0] e_addr;
        bit [3:0]  e_be;
        bit [31:0] e_wdata;
        bit        e_lv;
        bit        e_berr;
        bit [31:0] e_ld;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        dmem_ready = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input bit [2:0] f3, input int off, input bit [31:0] rd);
        longint v;
        if (f3[1]) return rd;
        if (f3[0]) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32768) v = v - 65536;
        end else begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (!f3[2] && v >= 128) v = v - 256;
        end
        return v[31:0];
    endfunction

    // Entered just after a rising edge with the DUT idle; leaves in the same position.
    task automatic run_txn(input string tag, input bit rd, input bit wr, input bit [2:0] f3,
                           input bit [31:0] addr, input bit [31:0] wdata, input bit [31:0] rdata,
                           input int k, input bit e_misal, input int e_stall,
                           input bit [31:0] e_addr, input bit [3:0] e_be, input bit [31:0] e_wdata,
                           input bit e_lv, input bit e_berr, input bit [31:0] e_ld);
        int          n;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_be;
        logic        c_we;
        bit          stable;
        n = 0; stable = 1'b1;
        c_addr = 'x; c_wdata = 'x; c_be = 'x; c_we = 1'bx;
        mem_read = rd; mem_write = wr; mem_funct3 = f3;
        mem_addr = addr; mem_wdata = wdata; dmem_rdata = rdata; dmem_ready = 1'b0;
        @(negedge clk);
        chk({tag, " misaligned"}, 32'(misaligned), 32'(e_misal));
        if (e_misal) begin
            chk({tag, " misal_stall"}, 32'(stall), 32'd0);
            chk({tag, " misal_req"}, 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk({tag, " misal_req_after"}, 32'(dmem_req), 32'd0);
            chk({tag, " misal_clear"}, 32'(misaligned), 32'd0);
        end else begin
            while (stall === 1'b1 && n < 300) begin
                n++;
                @(posedge clk); #1;
                dmem_ready = (n == k);
                @(negedge clk);
                if (stall === 1'b1) begin
                    if (n == 1) begin
                        c_addr = dmem_addr; c_be = dmem_be; c_wdata = dmem_wdata; c_we = dmem_we;
                    end else if (dmem_addr !== c_addr || dmem_be !== c_be ||
                                 dmem_wdata !== c_wdata || dmem_we !== c_we) begin
                        stable = 1'b0;
                    end
                    if (dmem_req !== 1'b1) stable = 1'b0;
                end
            end
            dmem_ready = 1'b0;
            chk({tag, " stall_cycles"}, 32'(n), 32'(e_stall));
            chk({tag, " dmem_addr"}, c_addr, e_addr);
            chk({tag, " dmem_be"}, 32'(c_be), 32'(e_be));
            chk({tag, " dmem_we"}, 32'(c_we), 32'(wr));
            if (wr) chk({tag, " dmem_wdata"}, c_wdata, e_wdata);
            chk({tag, " req_stable"}, 32'(stable), 32'd1);
            chk({tag, " req_done"}, 32'(dmem_req), 32'd0);
            chk({tag, " load_valid"}, 32'(load_valid), 32'(e_lv));
            chk({tag, " bus_err"}, 32'(bus_err), 32'(e_berr));
            chk({tag, " load_data"}, load_data, e_ld);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk({tag, " lv_width"}, 32'(load_valid), 32'd0);
            chk({tag, " berr_width"}, 32'(bus_err), 32'd0);
        end
        @(posedge clk); #1;
        $display("txn %s: rd=%0b wr=%0b f3=%0d addr=%h k=%0d stall_cycles=%0d load_data=%h",
                 tag, rd, wr, f3, addr, k, n, load_data);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0, 2, 32'h100, 4'hF, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 1, 1'b0, 2, 32'h100, 4'hF, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 1, 1'b0, 2, 32'h100, 4'hF, 32'h0, 1'b1, 1'b0, 32'h00000080};
        tbl[3]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 3, 1'b0, 4, 32'h100, 4'hC, 32'hABCDABCD, 1'b0, 1'b0, 32'h00000080};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80AABBCC, 2, 1'b0, 3, 32'h100, 4'hF, 32'h0, 1'b1, 1'b0, 32'hFFFF80AA};
        tbl[5]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80AABBCC, 1, 1'b0, 2, 32'h100, 4'hF, 32'h0, 1'b1, 1'b0, 32'h000080AA};
        tbl[6]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h12345655, 32'h0, 2, 1'b0, 3, 32'h100, 4'h2, 32'h55555555, 1'b0, 1'b0, 32'h000080AA};
        tbl[7]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1'b1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h000080AA};
        tbl[8]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1, 1'b1, 0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h000080AA};
        tbl[9]  = '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h55667788, 0, 1'b0, 5, 32'h200, 4'hF, 32'h0, 1'b0, 1'b1, 32'h000080AA};
        tbl[10] = '{1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h11223344, 4, 1'b0, 5, 32'h204, 4'hF, 32'h0, 1'b1, 1'b0, 32'h11223344};
        tbl[11] = '{1'b1, 1'b1, 3'b010, 32'h208, 32'h0000A5A5, 32'h0, 1, 1'b0, 2, 32'h208, 4'hF, 32'h0000A5A5, 1'b0, 1'b0, 32'h11223344};

        // Reset state, with an access presented while reset is held
        rstn = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; mem_funct3 = 3'b010;
        mem_addr = 32'h102; mem_wdata = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        #12;
        chk("rst misaligned", 32'(misaligned), 32'd0);
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_we", 32'(dmem_we), 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'd0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        chk("rst dmem_wdata", dmem_wdata, 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst load_valid", 32'(load_valid), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        mem_addr = 32'h100;
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr,
                    tbl[i].wdata, tbl[i].rdata, tbl[i].k, tbl[i].e_misal, tbl[i].e_stall,
                    tbl[i].e_addr, tbl[i].e_be, tbl[i].e_wdata, tbl[i].e_lv, tbl[i].e_berr,
                    tbl[i].e_ld);
            last_ld = tbl[i].e_ld;
        end

        for (int t = 0; t < 120; t++) begin
            int unsigned sel, kk;
            bit          rd, wr, e_mis, e_ok, e_lv;
            bit [2:0]    f3;
            bit [31:0]   addr, wd, rdt, e_wd, v, e_ld;
            bit [3:0]    e_be;
            int          k, sz, off, e_stall;
            sel  = $urandom_range(1, 3);
            rd   = sel[0];
            wr   = sel[1];
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
            wd   = $urandom;
            rdt  = $urandom;
            kk   = $urandom_range(0, 9);
            k    = (kk == 9) ? TO : int'(kk);
            sz   = f3[1] ? 4 : (f3[0] ? 2 : 1);
            off  = int'(addr % 4);
            e_mis   = (addr % 32'(sz)) != 0;
            e_ok    = (k >= 1) && (k <= TO);
            e_stall = e_ok ? 1 + k : 1 + TO;
            e_lv    = !e_mis && e_ok && !wr;
            if (!wr || sz == 4) e_be = 4'hF;
            else if (sz == 1)   e_be = 4'(1 << off);
            else                e_be = 4'(3 << (off & 2));
            if (sz == 1)      e_wd = (wd & 32'hFF) * 32'h01010101;
            else if (sz == 2) e_wd = (wd & 32'hFFFF) * 32'h00010001;
            else              e_wd = wd;
            v    = model_load(f3, off, rdt);
            e_ld = e_lv ? v : last_ld;
            run_txn($sformatf("rnd%0d", t), rd, wr, f3, addr, wd, rdt, k, e_mis, e_stall,
                    (addr / 4) * 4, e_be, e_wd, e_lv, e_ok ? 1'b0 : 1'b1, e_ld);
            last_ld = e_ld;
        end

        // Reset asserted in ACCESS cycle 2 abandons the access without strobes
        mem_read = 1'b1; mem_write = 1'b0; mem_funct3 = 3'b010;
        mem_addr = 32'h400; dmem_rdata = 32'h99999999; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst req_before", 32'(dmem_req), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst req_async", 32'(dmem_req), 32'd0);
        chk("midrst stall_async", 32'(stall), 32'd0);
        chk("midrst load_valid", 32'(load_valid), 32'd0);
        chk("midrst bus_err", 32'(bus_err), 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        chk("midrst load_data", load_data, 32'd0);
        chk("midrst dmem_addr", dmem_addr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        $display("txn midrst: reset during ACCESS cycle 2");

        // LW then SW back-to-back: second request 2 cycles after the first DONE
        mem_read = 1'b1; mem_write = 1'b0; mem_funct3 = 3'b010;
        mem_addr = 32'h300; dmem_rdata = 32'hCAFEF00D; dmem_ready = 1'b0;
        @(negedge clk);
        chk("b2b c0 stall", 32'(stall), 32'd1);
        chk("b2b c0 req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("b2b c1 req", 32'(dmem_req), 32'd1);
        chk("b2b c1 addr", dmem_addr, 32'h300);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("b2b c2 stall", 32'(stall), 32'd0);
        chk("b2b c2 load_valid", 32'(load_valid), 32'd1);
        chk("b2b c2 load_data", load_data, 32'hCAFEF00D);
        chk("b2b c2 req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b1; mem_addr = 32'h304; mem_wdata = 32'h0BADC0DE;
        @(negedge clk);
        chk("b2b c3 stall", 32'(stall), 32'd1);
        chk("b2b c3 req", 32'(dmem_req), 32'd0);
        chk("b2b c3 load_valid", 32'(load_valid), 32'd0);
        @(posedge clk); #1;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("b2b c4 req", 32'(dmem_req), 32'd1);
        chk("b2b c4 we", 32'(dmem_we), 32'd1);
        chk("b2b c4 addr", dmem_addr, 32'h304);
        chk("b2b c4 be", 32'(dmem_be), 32'hF);
        chk("b2b c4 wdata", dmem_wdata, 32'h0BADC0DE);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("b2b c5 stall", 32'(stall), 32'd0);
        chk("b2b c5 load_valid", 32'(load_valid), 32'd0);
        chk("b2b c5 bus_err", 32'(bus_err), 32'd0);
        chk("b2b c5 load_data", load_data, 32'hCAFEF00D);
        @(posedge clk); #1;
        idle_inputs();
        $display("txn b2b: LW 0x300 then SW 0x304");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
